// File: rtl/ika9958_prim_srl_bank.sv
// ika9958_prim_srl_bank
// Bank of WIDTH independent clocked SR latches sharing clock, clock enable
// and reset. MODE selects the S&R conflict rule, EDGE selects rising-edge
// sensitive inputs, RST_VAL gives per-channel reset values and o_CHG strobes
// whenever an o_Q bit changes.
// Optional feature: define IKA9958_SRL_BANK_INVALID_FLAG_EN to add the sticky
// per-channel o_INVALID flags and the i_FLAG_CLR input.
module ika9958_prim_srl_bank #(
    parameter int               WIDTH   = 8,
    parameter int               MODE    = 0,
    parameter int               EDGE    = 0,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             i_CLK,
    input  logic             i_RST_n,
    input  logic             i_CEN,
    input  logic [WIDTH-1:0] i_S,
    input  logic [WIDTH-1:0] i_R,
    output logic [WIDTH-1:0] o_Q,
    output logic [WIDTH-1:0] o_Q_n,
    output logic [WIDTH-1:0] o_CHG
`ifdef IKA9958_SRL_BANK_INVALID_FLAG_EN
    ,
    input  logic             i_FLAG_CLR,
    output logic [WIDTH-1:0] o_INVALID
`endif
);

    // Effective set/reset after optional edge detection.
    logic [WIDTH-1:0] s_eff;
    logic [WIDTH-1:0] r_eff;
    // Next latch state, evaluated for the coming CEN edge.
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] qn_next;

    generate
        if (EDGE != 0) begin : g_edge
            logic [WIDTH-1:0] s_prev;
            logic [WIDTH-1:0] r_prev;

            // Input history sampled at CEN rate; reset to ones so that inputs
            // held high across reset release are not seen as new edges.
            always_ff @(posedge i_CLK or negedge i_RST_n) begin
                if (!i_RST_n) begin
                    s_prev <= '1;
                    r_prev <= '1;
                end else if (i_CEN) begin
                    s_prev <= i_S;
                    r_prev <= i_R;
                end
            end

            assign s_eff = i_S & ~s_prev;
            assign r_eff = i_R & ~r_prev;
        end else begin : g_level
            assign s_eff = i_S;
            assign r_eff = i_R;
        end
    endgenerate

    // Per-channel next state from the effective inputs and the conflict rule.
    always_comb begin
        // NOTE: defaults first so every path assigns every bit (no latches).
        q_next  = o_Q;
        qn_next = o_Q_n;
        for (int i = 0; i < WIDTH; i++) begin
            case ({s_eff[i], r_eff[i]})
                2'b01: begin
                    q_next[i]  = 1'b0;
                    qn_next[i] = 1'b1;
                end
                2'b10: begin
                    q_next[i]  = 1'b1;
                    qn_next[i] = 1'b0;
                end
                2'b11: begin
                    case (MODE)
                        0: begin
                            q_next[i]  = 1'b0;
                            qn_next[i] = 1'b0;
                        end
                        1: begin
                            q_next[i]  = 1'b1;
                            qn_next[i] = 1'b0;
                        end
                        2: begin
                            q_next[i]  = 1'b0;
                            qn_next[i] = 1'b1;
                        end
                        default: begin
                            q_next[i]  = ~o_Q[i];
                            qn_next[i] = o_Q[i];
                        end
                    endcase
                end
                default: begin
                    q_next[i]  = o_Q[i];
                    qn_next[i] = o_Q_n[i];
                end
            endcase
        end
    end

    // Latch state and change strobe; Q_n is its own register so MODE 0 can
    // hold the 0/0 pair.
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            o_Q   <= RST_VAL;
            o_Q_n <= ~RST_VAL;
            o_CHG <= '0;
        end else begin
            // NOTE: non-blocking assignments for all sequential state.
            o_CHG <= i_CEN ? (q_next ^ o_Q) : '0;
            if (i_CEN) begin
                o_Q   <= q_next;
                o_Q_n <= qn_next;
            end
        end
    end

`ifdef IKA9958_SRL_BANK_INVALID_FLAG_EN
    // Sticky conflict flags; a new conflict wins over a simultaneous clear.
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            o_INVALID <= '0;
        end else begin
            o_INVALID <= (i_FLAG_CLR ? '0 : o_INVALID)
                       | (i_CEN ? (s_eff & r_eff) : '0);
        end
    end
`else
    // Conflict flags are not built in this configuration.
`endif

endmodule

// File: tb/tb_ika9958_prim_srl_bank.sv
// Testbench for ika9958_prim_srl_bank: five instances (MODE 0..3 level, plus
// an EDGE=1 instance) share stimulus; directed scenarios use fixed expected
// values and a randomized phase compares every instance with a vector model.
// Flag checks are compiled when IKA9958_SRL_BANK_INVALID_FLAG_EN is defined.
`timescale 1ns/1ps
module tb_ika9958_prim_srl_bank;

    localparam int N = 5;

    function automatic int mode_of(input int k);
        case (k)
            1: return 1;
            2: return 2;
            3: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int edge_of(input int k);
        return (k == 4) ? 1 : 0;
    endfunction

    function automatic logic [7:0] rst_of(input int k);
        return (k == 0) ? 8'hA5 : 8'h00;
    endfunction

    logic       clk;
    logic       rst_n;
    logic       cen;
    logic [7:0] s_in;
    logic [7:0] r_in;
    logic       flag_clr;

    wire [7:0] dq   [N];
    wire [7:0] dqn  [N];
    wire [7:0] dchg [N];
    wire [7:0] dinv [N];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [7:0] mq   [N];
    logic [7:0] mqn  [N];
    logic [7:0] mchg [N];
    logic [7:0] msp  [N];
    logic [7:0] mrp  [N];
    logic [7:0] minv [N];

    for (genvar k = 0; k < N; k++) begin : g_dut
        ika9958_prim_srl_bank #(
            .WIDTH  (8),
            .MODE   (mode_of(k)),
            .EDGE   (edge_of(k)),
            .RST_VAL(rst_of(k))
        ) u_dut (
            .i_CLK  (clk),
            .i_RST_n(rst_n),
            .i_CEN  (cen),
            .i_S    (s_in),
            .i_R    (r_in),
            .o_Q    (dq[k]),
            .o_Q_n  (dqn[k]),
            .o_CHG  (dchg[k])
`ifdef IKA9958_SRL_BANK_INVALID_FLAG_EN
            ,
            .i_FLAG_CLR(flag_clr),
            .o_INVALID (dinv[k])
`endif
        );
`ifndef IKA9958_SRL_BANK_INVALID_FLAG_EN
        assign dinv[k] = 8'h00;
`endif
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mq[k]   = rst_of(k);
            mqn[k]  = ~rst_of(k);
            mchg[k] = 8'h00;
            msp[k]  = 8'hFF;
            mrp[k]  = 8'hFF;
            minv[k] = 8'h00;
        end
    endtask

    // Apply the latch rules, written as whole-vector set/clear/toggle masks.
    task automatic model_update();
        logic [7:0] es, er, hold, so, ro, bo, nq, nqn;
        if (!rst_n) return;
        for (int k = 0; k < N; k++) begin
            bo = 8'h00;
            if (cen) begin
                es = (edge_of(k) != 0) ? (s_in & ~msp[k]) : s_in;
                er = (edge_of(k) != 0) ? (r_in & ~mrp[k]) : r_in;
                msp[k] = s_in;
                mrp[k] = r_in;
                hold = ~es & ~er;
                so   = es & ~er;
                ro   = ~es & er;
                bo   = es & er;
                case (mode_of(k))
                    0: begin nq = (mq[k] & hold) | so; nqn = (mqn[k] & hold) | ro; end
                    1: begin nq = (mq[k] & hold) | es; nqn = (mqn[k] & hold) | ro; end
                    2: begin nq = (mq[k] & hold) | so; nqn = (mqn[k] & hold) | er; end
                    default: begin
                        nq  = (mq[k] & hold) | so | (bo & ~mq[k]);
                        nqn = (mqn[k] & hold) | ro | (bo & mq[k]);
                    end
                endcase
                mchg[k] = nq ^ mq[k];
                mq[k]   = nq;
                mqn[k]  = nqn;
            end else begin
                mchg[k] = 8'h00;
            end
            minv[k] = (flag_clr ? 8'h00 : minv[k]) | bo;
        end
    endtask

    // One clock: model follows the edge, outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        #7 rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++; if (dq[0] !== 8'hA5) begin n_fail++; $display("FAIL rst_q got=%h exp=a5", dq[0]); end
        n_tests++; if (dqn[0] !== 8'h5A) begin n_fail++; $display("FAIL rst_qn got=%h exp=5a", dqn[0]); end
        n_tests++; if (dchg[0] !== 8'h00) begin n_fail++; $display("FAIL rst_chg got=%h exp=00", dchg[0]); end
        tick();
        tick();
        #2 rst_n = 1'b1;
        // Disturb the state, then reset mid-cycle with no clock edge.
        cen = 1'b1; s_in = 8'hFF; r_in = 8'h00;
        tick();
        n_tests++; if (dq[0] !== 8'hFF) begin n_fail++; $display("FAIL rst_pre_q got=%h exp=ff", dq[0]); end
        s_in = 8'h00;
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++; if (dq[0] !== 8'hA5 || dqn[0] !== 8'h5A) begin
            n_fail++; $display("FAIL rst_mid q=%h qn=%h exp=a5/5a", dq[0], dqn[0]); end
        n_tests++; if (dq[1] !== 8'h00 || dqn[1] !== 8'hFF) begin
            n_fail++; $display("FAIL rst_mid1 q=%h qn=%h exp=00/ff", dq[1], dqn[1]); end
        tick();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_level_mode0();
        logic [7:0] s_tab   [8] = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01};
        logic [7:0] r_tab   [8] = '{8'hFF, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00};
        logic [7:0] q_tab   [8] = '{8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        logic [7:0] qn_tab  [8] = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFE, 8'hFE};
        logic [7:0] chg_tab [8] = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
        cen = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_in = s_tab[i];
            r_in = r_tab[i];
            tick();
            n_tests++; if (dq[0] !== q_tab[i] || dqn[0] !== qn_tab[i] || dchg[0] !== chg_tab[i]) begin
                n_fail++;
                $display("FAIL level_step%0d q/qn/chg got=%h/%h/%h exp=%h/%h/%h",
                         i, dq[0], dqn[0], dchg[0], q_tab[i], qn_tab[i], chg_tab[i]);
            end
        end
        s_in = 8'h00; r_in = 8'h00;
    endtask

    task automatic test_modes();
        logic [7:0] exp3;
        cen = 1'b1; s_in = 8'h00; r_in = 8'hFF;
        tick();
        s_in = 8'hFF; r_in = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp3 = (i % 2 == 0) ? 8'hFF : 8'h00;
            n_tests++; if (dq[1] !== 8'hFF || dqn[1] !== 8'h00) begin
                n_fail++; $display("FAIL mode1_c%0d q/qn got=%h/%h exp=ff/00", i, dq[1], dqn[1]); end
            n_tests++; if (dq[2] !== 8'h00 || dqn[2] !== 8'hFF) begin
                n_fail++; $display("FAIL mode2_c%0d q/qn got=%h/%h exp=00/ff", i, dq[2], dqn[2]); end
            n_tests++; if (dq[3] !== exp3 || dqn[3] !== ~exp3 || dchg[3] !== 8'hFF) begin
                n_fail++;
                $display("FAIL mode3_c%0d q/qn/chg got=%h/%h/%h exp=%h/%h/ff",
                         i, dq[3], dqn[3], dchg[3], exp3, ~exp3);
            end
        end
        s_in = 8'h00; r_in = 8'h00;
    endtask

    task automatic test_cen_gating();
        // cen high on cycles 0,4,8; S pulse on cycle 1 only, S=02 on 5..8.
        logic [7:0] s_tab [10] = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                                   8'h02, 8'h02, 8'h02, 8'h02, 8'h00};
        logic [7:0] q_exp, chg_exp;
        cen = 1'b1; s_in = 8'h00; r_in = 8'hFF;
        tick();
        r_in = 8'h00;
        for (int i = 0; i < 10; i++) begin
            cen  = (i % 4 == 0);
            s_in = s_tab[i];
            tick();
            q_exp   = (i >= 8) ? 8'h02 : 8'h00;
            chg_exp = (i == 8) ? 8'h02 : 8'h00;
            n_tests++; if (dq[0] !== q_exp || dchg[0] !== chg_exp) begin
                n_fail++;
                $display("FAIL cen_c%0d q/chg got=%h/%h exp=%h/%h", i, dq[0], dchg[0], q_exp, chg_exp);
            end
        end
        cen = 1'b1; s_in = 8'h00;
    endtask

    task automatic test_edge();
        cen = 1'b1; s_in = 8'hFF; r_in = 8'h00;
        #2 rst_n = 1'b0;
        model_reset();
        tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (dq[4] !== 8'h00 || dchg[4] !== 8'h00) begin
                n_fail++; $display("FAIL edge_held_c%0d q/chg got=%h/%h exp=00/00", i, dq[4], dchg[4]); end
        end
        s_in = 8'h00; tick();
        s_in = 8'hFF; tick();
        n_tests++; if (dq[4] !== 8'hFF || dqn[4] !== 8'h00 || dchg[4] !== 8'hFF) begin
            n_fail++; $display("FAIL edge_rise q/qn/chg got=%h/%h/%h exp=ff/00/ff", dq[4], dqn[4], dchg[4]); end
        tick();
        n_tests++; if (dq[4] !== 8'hFF || dchg[4] !== 8'h00) begin
            n_fail++; $display("FAIL edge_hold q/chg got=%h/%h exp=ff/00", dq[4], dchg[4]); end
        s_in = 8'h00; tick();
        s_in = 8'hFF; tick();
        r_in = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++; if (dq[4] !== 8'h00 || dqn[4] !== 8'hFF || dchg[4] !== ((i == 0) ? 8'hFF : 8'h00)) begin
                n_fail++;
                $display("FAIL edge_r_c%0d q/qn/chg got=%h/%h/%h exp=00/ff/%h",
                         i, dq[4], dqn[4], dchg[4], (i == 0) ? 8'hFF : 8'h00);
            end
        end
        s_in = 8'h00; r_in = 8'h00;
    endtask

`ifdef IKA9958_SRL_BANK_INVALID_FLAG_EN
    task automatic test_flag();
        cen = 1'b1; s_in = 8'h00; r_in = 8'h00; flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0; s_in = 8'h04; r_in = 8'h04;
        tick();
        n_tests++; if (dinv[0] !== 8'h04) begin n_fail++; $display("FAIL flag_set got=%h exp=04", dinv[0]); end
        s_in = 8'h00; r_in = 8'h00;
        tick();
        n_tests++; if (dinv[0] !== 8'h04) begin n_fail++; $display("FAIL flag_sticky got=%h exp=04", dinv[0]); end
        flag_clr = 1'b1; s_in = 8'h04; r_in = 8'h04;
        tick();
        n_tests++; if (dinv[0] !== 8'h04) begin n_fail++; $display("FAIL flag_set_wins got=%h exp=04", dinv[0]); end
        s_in = 8'h00; r_in = 8'h00;
        tick();
        n_tests++; if (dinv[0] !== 8'h00) begin n_fail++; $display("FAIL flag_clear got=%h exp=00", dinv[0]); end
        flag_clr = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cen      = ($urandom_range(0, 3) != 0);
            s_in     = 8'($urandom) & 8'($urandom);
            r_in     = 8'($urandom) & 8'($urandom);
            flag_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 59) == 0) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1;
                for (int k = 0; k < N; k++) begin
                    n_tests++; if (dq[k] !== mq[k] || dqn[k] !== mqn[k] || dchg[k] !== 8'h00) begin
                        n_fail++;
                        $display("FAIL rand_rst dut%0d q/qn/chg got=%h/%h/%h exp=%h/%h/00",
                                 k, dq[k], dqn[k], dchg[k], mq[k], mqn[k]);
                    end
                end
                tick();
                #2 rst_n = 1'b1;
            end
            tick();
            for (int k = 0; k < N; k++) begin
                n_tests++; if (dq[k] !== mq[k] || dqn[k] !== mqn[k] || dchg[k] !== mchg[k]) begin
                    n_fail++;
                    $display("FAIL rand_c%0d dut%0d q/qn/chg got=%h/%h/%h exp=%h/%h/%h",
                             i, k, dq[k], dqn[k], dchg[k], mq[k], mqn[k], mchg[k]);
                end
`ifdef IKA9958_SRL_BANK_INVALID_FLAG_EN
                n_tests++; if (dinv[k] !== minv[k]) begin
                    n_fail++; $display("FAIL rand_inv_c%0d dut%0d got=%h exp=%h", i, k, dinv[k], minv[k]);
                end
`endif
            end
        end
        flag_clr = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b1;
        cen      = 1'b0;
        s_in     = 8'h00;
        r_in     = 8'h00;
        flag_clr = 1'b0;
        model_reset();
        test_reset();
        test_level_mode0();
        test_modes();
        test_cen_gating();
        test_edge();
`ifdef IKA9958_SRL_BANK_INVALID_FLAG_EN
        test_flag();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ika9958_prim_srl_bank.md
Name: ika9958_prim_srl_bank

Overview:
Parametrised bank of WIDTH independent clocked SR latches sharing one clock, clock enable and reset. Successor to the single-bit clocked SR primitive, adding:
- selectable conflict-resolution mode (NOR / set-dominant / reset-dominant / JK toggle)
- optional edge-triggered inputs
- per-channel reset values
- per-channel change strobes
Used for VDP status/interrupt flags, sprite collision latches and command-engine busy bits.

Parameters:
WIDTH, 8, number of latch channels (1..32)
MODE, 0, S&R conflict rule: 0 = NOR-invalid (Q=0, Q_n=0), 1 = set-dominant, 2 = reset-dominant, 3 = JK toggle
EDGE, 0, 0 = level-sensitive S/R; 1 = rising-edge-sensitive S/R, sampled on CEN cycles
RST_VAL, {WIDTH{1'b0}}, per-channel o_Q value after reset

Ports:
i_CLK  in  1  master clock; all state on rising edge
i_RST_n  in  1  asynchronous active-low reset
i_CEN  in  1  clock enable; latch and edge-detector state update only when 1
i_S  in  WIDTH  per-channel set
i_R  in  WIDTH  per-channel reset
o_Q  out  WIDTH  latch outputs
o_Q_n  out  WIDTH  complementary outputs (independent register, not derived by inversion)
o_CHG  out  WIDTH  one-i_CLK-cycle strobe: o_Q bit changed on this edge

Behaviour:
- Reset (i_RST_n=0, asynchronous, any time including mid-operation):
  - o_Q = RST_VAL, o_Q_n = ~RST_VAL, o_CHG = 0.
  - Edge-detector history registers = all ones, so inputs held high across reset do not fire.
  - Reset release is synchronous to the next i_CLK edge; no update on the deasserting edge itself is required.
- Effective inputs per channel i:
  - EDGE=0: s = i_S[i], r = i_R[i].
  - EDGE=1: s = i_S[i] & ~s_prev[i], r = i_R[i] & ~r_prev[i].
  - s_prev/r_prev load i_S/i_R only on CEN cycles, so edges are detected at CEN sample rate.
- Update on rising i_CLK with i_CEN=1, per channel:
  - {s,r}=00: hold both Q and Q_n.
  - 01: Q=0, Q_n=1.
  - 10: Q=1, Q_n=0.
  - 11, MODE 0: Q=0, Q_n=0. Subsequent 00 holds the invalid 0/0 pair. Next 01 or 10 restores a complementary pair.
  - 11, MODE 1: as 10.
  - 11, MODE 2: as 01.
  - 11, MODE 3: Q=~Q, Q_n=Q (toggle every CEN cycle while held in level mode; once per edge in EDGE mode).
- i_CEN=0:
  - Q, Q_n and edge history hold.
  - i_S/i_R are ignored; pulses shorter than a CEN period that fall between CEN cycles are lost by design.
- Latency: new o_Q/o_Q_n visible one i_CLK edge after the CEN sample; no combinational path from inputs to outputs.
- o_CHG[i]:
  - Registered: <= i_CEN & (Q_next[i] != o_Q[i]).
  - Asserted in the same cycle the new o_Q value appears; cleared on the next i_CLK edge regardless of CEN.
  - Q_n-only changes (MODE 0 entering 0/0 from Q=0) do not strobe.
- Channels are fully independent; simultaneous events on different channels are all applied in the same cycle.

Optional Feature:
Macro IKA9958_SRL_BANK_INVALID_FLAG_EN.
- Defined:
  - Adds output o_INVALID (WIDTH) and input i_FLAG_CLR (1).
  - o_INVALID[i] is sticky; set on any CEN cycle with effective s&r=1 on channel i, in every MODE.
  - i_FLAG_CLR=1 clears all bits on the next i_CLK edge, independent of CEN. Simultaneous set and clear: set wins.
  - Reset value 0.
- Not defined: ports absent; no flag logic synthesised; behaviour otherwise identical.

Test Plan:
1. Reset: WIDTH=8, RST_VAL=8'hA5, i_RST_n pulsed low mid-clock -> o_Q=8'hA5, o_Q_n=8'h5A, o_CHG=0 immediately, without a clock edge.
2. Level, MODE 0, CEN every cycle:
   - S=8'h01 -> o_Q=8'h01, o_CHG=8'h01 for one cycle.
   - S=R=8'h01 -> o_Q[0]=0 and o_Q_n[0]=0.
   - S=R=0 -> both stay 0.
   - R=8'h01 -> o_Q_n[0]=1.
3. Modes 1/2/3, S=R=8'hFF held 4 CEN cycles from Q=0:
   - MODE 1 -> o_Q=8'hFF.
   - MODE 2 -> o_Q=8'h00.
   - MODE 3 -> o_Q alternates FF,00,FF,00 and o_CHG=8'hFF each cycle.
4. CEN gating: CEN high 1 cycle in 4; S pulse of 1 cycle placed between CEN cycles -> no change. S held across a CEN cycle -> o_Q set exactly at that edge.
5. EDGE=1: S held high through reset release -> no set. S low then high -> set once. R held high 10 CEN cycles after a new S edge -> single clear, then hold.
6. With IKA9958_SRL_BANK_INVALID_FLAG_EN:
   - S=R=8'h04 for 1 CEN cycle -> o_INVALID=8'h04, persisting after S/R drop.
   - i_FLAG_CLR coincident with a new conflict on bit 2 -> bit 2 remains set.
   - i_FLAG_CLR alone -> o_INVALID=0.
